step_clock_controller: RTL

- Generates the CPU clock-enable, replacing free-running slow clocking with operator-controlled sequencing.
- Modes: paused, single-step (one enable per button press), run (one enable every RUN_DIV cycles), and halted (the CPU's HLT locks out further enables).
- Sits between the board buttons and the computer's clock-enable input. Runs on the PLL clock with the system reset.

---
 rtl/step_clock_controller_pkg.sv | 13 +
 rtl/step_clock_controller_button_debouncer.sv | 55 +++++
 rtl/step_clock_controller.sv | 115 +++++++++++
 3 files changed

// File: rtl/step_clock_controller_pkg.sv
// Shared constants for the step clock controller: FSM state encodings and counter width.
package step_clock_controller_pkg;

    typedef enum logic [1:0] {
        ST_PAUSED  = 2'd0,
        ST_RUNNING = 2'd1,
        ST_HALTED  = 2'd2,
        ST_INVALID = 2'd3
    } state_e;

    localparam int unsigned STEP_COUNT_W = 16;

endpackage

// File: rtl/step_clock_controller_button_debouncer.sv
// Button conditioning: 2-flop synchronizer, stable-level debounce, registered press pulse.
module button_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 200_000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic press_o
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             level_q;
    logic             level_d;
    logic             press_q;
    logic             press_d;

    // Counter only advances while the synced level disagrees with the accepted level.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_MAX) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        press_d = level_d & ~level_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/step_clock_controller.sv
// CPU clock-enable sequencer: paused / single-step / free-run / halted, driven by debounced buttons.
module step_clock_controller
    import step_clock_controller_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 200_000,
    parameter int unsigned RUN_DIV         = 1_200_000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    btn_step,
    input  logic                    btn_run,
    input  logic                    cpu_halt,
    output logic                    cpu_clk_en,
    output logic                    running,
    output logic                    halted,
    output logic [STEP_COUNT_W-1:0] step_count
);

    localparam int unsigned DIV_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(RUN_DIV - 1);

    state_e                  state_q;
    state_e                  state_d;
    logic [DIV_W-1:0]        div_q;
    logic [DIV_W-1:0]        div_d;
    logic                    en_q;
    logic                    en_d;
    logic                    running_q;
    logic                    running_d;
    logic                    halted_q;
    logic                    halted_d;
    logic [STEP_COUNT_W-1:0] count_q;
    logic [STEP_COUNT_W-1:0] count_d;
    logic                    step_press;
    logic                    run_press;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_step_btn (
        .clk_i  (clk),
        .rst_i  (reset),
        .btn_i  (btn_step),
        .press_o(step_press)
    );

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_run_btn (
        .clk_i  (clk),
        .rst_i  (reset),
        .btn_i  (btn_run),
        .press_o(run_press)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_PAUSED;
            div_q   <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
        end
    end

    // Divider defaults to zero, so any entry into RUNNING starts a fresh period.
    always_comb begin
        state_d = state_q;
        div_d   = '0;
        case (state_q)
            ST_PAUSED: begin
                if (cpu_halt)       state_d = ST_HALTED;
                else if (run_press) state_d = ST_RUNNING;
            end
            ST_RUNNING: begin
                if (cpu_halt)       state_d = ST_HALTED;
                else if (run_press) state_d = ST_PAUSED;
                else                div_d   = (div_q == DIV_MAX) ? '0 : div_q + 1'b1;
            end
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_PAUSED;
        endcase
    end

    always_comb begin
        en_d = 1'b0;
        case (state_q)
            ST_PAUSED:  en_d = step_press & ~run_press & ~cpu_halt;
            ST_RUNNING: en_d = (div_q == DIV_MAX) & ~run_press & ~cpu_halt;
            default:    en_d = 1'b0;
        endcase
        running_d = (state_d == ST_RUNNING);
        halted_d  = (state_d == ST_HALTED);
        count_d   = en_q ? count_q + 1'b1 : count_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            en_q      <= 1'b0;
            running_q <= 1'b0;
            halted_q  <= 1'b0;
            count_q   <= '0;
        end else begin
            en_q      <= en_d;
            running_q <= running_d;
            halted_q  <= halted_d;
            count_q   <= count_d;
        end
    end

    assign cpu_clk_en = en_q;
    assign running    = running_q;
    assign halted     = halted_q;
    assign step_count = count_q;

endmodule
